// File: rtl/exc_ctrl.sv
// exc_ctrl: precise-exception / ERET sequencer at the MEM commit point; arbitrates causes,
// drains outstanding AXI data traffic, then pulses the CP0 update, flush and PC redirect.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [31:0] pc_m,
  input  logic        is_ds_m,
  input  logic [5:0]  exc_vec,
  input  logic        data_is_store,
  input  logic [31:0] data_addr,
  input  logic        eret_m,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic [7:0]  cause_ip,
  input  logic [31:0] epc_cur,
  input  logic        mem_busy,
  output logic        stall,
  output logic        flush,
  output logic        cp0_we,
  output logic [4:0]  exc_code,
  output logic [31:0] epc_out,
  output logic        bd_out,
  output logic        badvaddr_we,
  output logic [31:0] badvaddr_out,
  output logic        exl_clr,
  output logic        redirect,
  output logic [31:0] redirect_pc
);
  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, REDIR} state_t;
  state_t state, state_nx;
  logic int_req, exc_any, event_v, bv_hit, eret_l, bv_l;
  logic [4:0] code_nx;
  assign int_req = status_ie & ~status_exl & |(status_im & cause_ip);
  assign exc_any = int_req | |exc_vec;
  assign event_v = commit_valid & (exc_any | eret_m);
  // BadVAddr is only written when a fetch or data address error wins arbitration
  assign bv_hit  = ~int_req & (exc_vec[0] | (exc_vec[5] & ~|exc_vec[4:0]));
  always_comb begin
    code_nx  = int_req ? 5'h00 : exc_vec[0] ? 5'h04 : exc_vec[1] ? 5'h0A : exc_vec[2] ? 5'h0C :
               exc_vec[3] ? 5'h08 : exc_vec[4] ? 5'h09 : data_is_store ? 5'h05 : 5'h04;
    state_nx = state == IDLE   ? (event_v ? (mem_busy ? DRAIN : COMMIT) : IDLE) :
               state == DRAIN  ? (mem_busy ? DRAIN : COMMIT) :
               state == COMMIT ? REDIR : IDLE;
  end
  assign stall       = state != IDLE;
  assign flush       = state == COMMIT;
  assign cp0_we      = flush & ~eret_l;
  assign badvaddr_we = cp0_we & bv_l;
  assign exl_clr     = flush & eret_l;
  assign redirect    = state == REDIR;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      eret_l       <= 1'b0;
      bv_l         <= 1'b0;
      exc_code     <= 5'h00;
      epc_out      <= 32'h0;
      bd_out       <= 1'b0;
      badvaddr_out <= 32'h0;
      redirect_pc  <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == IDLE && event_v) begin
        eret_l      <= ~exc_any;
        bv_l        <= bv_hit;
        redirect_pc <= exc_any ? EXC_VECTOR : epc_cur;
        if (exc_any) begin
          exc_code <= code_nx;
          epc_out  <= is_ds_m ? pc_m - 32'd4 : pc_m;
          bd_out   <= is_ds_m;
        end
        if (bv_hit) badvaddr_out <= exc_vec[0] ? pc_m : data_addr;
      end
    end
  end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: scoreboard bench for exc_ctrl; stimulus pushes expected commit/redirect
// records, a negedge monitor pops them when the DUT pulses flush or redirect.
module tb_exc_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic commit_valid, is_ds_m, data_is_store, eret_m, status_ie, status_exl, mem_busy;
  logic [31:0] pc_m, data_addr, epc_cur;
  logic [5:0] exc_vec;
  logic [7:0] status_im, cause_ip;
  logic stall, flush, cp0_we, bd_out, badvaddr_we, exl_clr, redirect;
  logic [4:0] exc_code;
  logic [31:0] epc_out, badvaddr_out, redirect_pc;

  exc_ctrl dut (.clk(clk), .rst(rst), .commit_valid(commit_valid), .pc_m(pc_m), .is_ds_m(is_ds_m),
    .exc_vec(exc_vec), .data_is_store(data_is_store), .data_addr(data_addr), .eret_m(eret_m),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im), .cause_ip(cause_ip),
    .epc_cur(epc_cur), .mem_busy(mem_busy), .stall(stall), .flush(flush), .cp0_we(cp0_we),
    .exc_code(exc_code), .epc_out(epc_out), .bd_out(bd_out), .badvaddr_we(badvaddr_we),
    .badvaddr_out(badvaddr_out), .exl_clr(exl_clr), .redirect(redirect), .redirect_pc(redirect_pc));

  always #5 clk = ~clk;

  typedef struct {
    logic        is_exc;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        bvwe;
    logic [31:0] bv;
    logic [31:0] rpc;
    int          ccyc;
  } exp_t;

  exp_t cq[$], rq[$], me;
  int cyc = 0, errors = 0, checks = 0, s0 = -1, s1 = -1;
  logic [4:0]  m_code = 5'h0;
  logic [31:0] m_epc = 32'h0, m_bv = 32'h0;
  logic        m_bd = 1'b0;
  logic [4:0]  ct [5] = '{5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 0);
    chk({tag, "_flush"}, 32'(flush), 0);
    chk({tag, "_cp0_we"}, 32'(cp0_we), 0);
    chk({tag, "_exc_code"}, 32'(exc_code), 0);
    chk({tag, "_epc_out"}, epc_out, 0);
    chk({tag, "_bd_out"}, 32'(bd_out), 0);
    chk({tag, "_badvaddr_we"}, 32'(badvaddr_we), 0);
    chk({tag, "_badvaddr_out"}, badvaddr_out, 0);
    chk({tag, "_exl_clr"}, 32'(exl_clr), 0);
    chk({tag, "_redirect"}, 32'(redirect), 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
  endtask

  always @(negedge clk) if (rst) begin
    chk("stall", 32'(stall), 32'(cyc >= s0 && cyc <= s1));
    if (flush) begin
      if (cq.size() == 0) chk("flush_unexpected", 32'(flush), 0);
      else begin
        me = cq.pop_front();
        chk("commit_cycle", 32'(cyc), 32'(me.ccyc));
        chk("cp0_we", 32'(cp0_we), 32'(me.is_exc));
        chk("exl_clr", 32'(exl_clr), 32'(!me.is_exc));
        chk("badvaddr_we", 32'(badvaddr_we), 32'(me.bvwe));
        chk("exc_code", 32'(exc_code), 32'(me.code));
        chk("epc_out", epc_out, me.epc);
        chk("bd_out", 32'(bd_out), 32'(me.bd));
        chk("badvaddr_out", badvaddr_out, me.bv);
      end
    end else if (cp0_we || exl_clr || badvaddr_we)
      chk("pulse_without_flush", 32'({cp0_we, exl_clr, badvaddr_we}), 0);
    if (redirect) begin
      if (rq.size() == 0) chk("redirect_unexpected", 32'(redirect), 0);
      else begin
        me = rq.pop_front();
        chk("redirect_cycle", 32'(cyc), 32'(me.ccyc + 1));
        chk("redirect_pc", redirect_pc, me.rpc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    commit_valid = 0; pc_m = 0; is_ds_m = 0; exc_vec = 0; data_is_store = 0; data_addr = 0;
    eret_m = 0; status_ie = 0; status_exl = 0; status_im = 0; cause_ip = 0; epc_cur = 0;
    mem_busy = 0;
  endtask

  task automatic rnd_inputs();
    commit_valid = ($urandom % 4) != 0;
    pc_m = $urandom; is_ds_m = 1'($urandom); data_addr = $urandom; data_is_store = 1'($urandom);
    exc_vec = 6'($urandom & $urandom & $urandom);
    eret_m = ($urandom % 4) == 0;
    status_ie = 1'($urandom); status_exl = 1'($urandom);
    status_im = 8'($urandom); cause_ip = 8'($urandom & $urandom);
    epc_cur = $urandom;
  endtask

  // Reference model: applies the arbitration rules to the inputs currently driven,
  // schedules expectations, and plays out the sequence with junk inputs that must be ignored.
  task automatic run(input int nb);
    logic ir, isx, ev;
    int t, first;
    exp_t e;
    mem_busy = nb > 0;
    ir  = status_ie && !status_exl && (status_im & cause_ip) != 0;
    isx = ir || exc_vec != 0;
    ev  = commit_valid && (isx || eret_m);
    t   = cyc;
    if (!ev) begin
      step();
      return;
    end
    first = -1;
    for (int k = 0; k < 6; k++) if (exc_vec[k] && first < 0) first = k;
    e.bvwe = isx && !ir && (first == 0 || first == 5);
    if (isx) begin
      m_code = ir ? 5'h00 : first == 5 ? (data_is_store ? 5'h05 : 5'h04) : ct[first];
      m_epc  = is_ds_m ? pc_m - 32'd4 : pc_m;
      m_bd   = is_ds_m;
      if (e.bvwe) m_bv = first == 0 ? pc_m : data_addr;
    end
    e.is_exc = isx; e.code = m_code; e.epc = m_epc; e.bd = m_bd; e.bv = m_bv;
    e.rpc = isx ? 32'hBFC0_0380 : epc_cur;
    e.ccyc = t + 1 + nb;
    cq.push_back(e);
    rq.push_back(e);
    s0 = t + 1;
    s1 = t + 2 + nb;
    for (int k = 1; k < 3 + nb; k++) begin
      step();
      rnd_inputs();
      mem_busy = k < nb;
    end
    step();
    clr();
  endtask

  initial begin
    clr();
    #12;
    chk_zero("reset");
    rst = 1;
    step();
    // Syscall alone
    clr(); commit_valid = 1; pc_m = 32'h8000_1000; exc_vec = 6'b001000;
    run(0);
    // delay-slot data AdES
    clr(); commit_valid = 1; pc_m = 32'h8000_2004; is_ds_m = 1; exc_vec = 6'b100000;
    data_addr = 32'h1235; data_is_store = 1;
    run(0);
    // interrupt beats RI, then RI alone without BadVAddr
    clr(); commit_valid = 1; exc_vec = 6'b100010; status_ie = 1; status_im = 8'h04; cause_ip = 8'h04;
    pc_m = 32'h8000_4000;
    run(0);
    clr(); commit_valid = 1; exc_vec = 6'b100010; pc_m = 32'h8000_4008; data_addr = 32'h77;
    run(0);
    // fetch AdEL with wraparound delay-slot EPC
    clr(); commit_valid = 1; exc_vec = 6'b000001; pc_m = 32'h0000_0002; is_ds_m = 1;
    run(0);
    // ERET draining three busy cycles
    clr(); commit_valid = 1; eret_m = 1; epc_cur = 32'h8000_3000;
    run(3);
    // ERET loses to Ov
    clr(); commit_valid = 1; eret_m = 1; exc_vec = 6'b000100; pc_m = 32'h8000_5000; epc_cur = 32'h1;
    run(1);
    // interrupt masked by EXL: no event
    clr(); commit_valid = 1; status_ie = 1; status_exl = 1; status_im = 8'hFF; cause_ip = 8'h01;
    run(0); run(0);
    // invalid commit slot: no event
    clr(); exc_vec = 6'b111111; eret_m = 1;
    run(0);
    repeat (300) begin
      rnd_inputs();
      run(($urandom % 3) == 0 ? int'($urandom_range(1, 4)) : 0);
    end
    // reset dropped while draining
    clr(); commit_valid = 1; exc_vec = 6'b000010; pc_m = 32'h8000_6000; mem_busy = 1;
    s0 = cyc + 1; s1 = cyc + 100;
    step(); clr(); mem_busy = 1;
    step();
    #2 rst = 0;
    #1 chk_zero("reset_drain");
    cq.delete(); rq.delete();
    s0 = -1; s1 = -1;
    m_code = 0; m_epc = 0; m_bd = 0; m_bv = 0;
    clr();
    #3 rst = 1;
    step();
    clr(); commit_valid = 1; exc_vec = 6'b010000; pc_m = 32'h8000_7000;
    run(0);
    step(); step(); step();
    chk("queues_drained", 32'(cq.size() + rq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
